approx_mul_pipe: RTL
====================

Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed unsigned 8x8 half-adder-array partial-product generator.
- Generates WIDTH x WIDTH unsigned partial products and pairs adjacent rows.
- In the low APPROX_COLS columns, each row pair is combined with OR instead of an exact half-adder; a per-transaction mode bit selects fully exact operation.
- Compresses and sums in a 3-stage valid/ready pipeline and keeps a transaction counter. Sits between operand producers and error-evaluation / accumulation logic in the multiplier test fabric.

Parameters:
- WIDTH, 8, operand width; even, 4..16.
- APPROX_COLS, 4, number of LSB product columns (0..2*WIDTH-1) using OR pair-combining; 0 = always exact.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  pipeline can accept operands this cycle.
- x  in  WIDTH  multiplicand, unsigned.
- y  in  WIDTH  multiplier, unsigned.
- exact  in  1  1 = exact product for this transaction, 0 = approximate.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  product, approximate or exact.
- p_exact_flag  out  1  exact bit carried with the product.
- txn_count  out  CNT_W  accepted transactions, saturating.

Behaviour:
- Partial products: pp[i][j] = y[i] & x[j], weight 2^(i+j). Row i = all pp[i][*].
- Rows pair as (2k, 2k+1), k = 0..WIDTH/2-1.
- Approximation rule, applied only when exact = 0: for each column c < APPROX_COLS where both pp[2k][c-2k] and pp[2k+1][c-2k-1] exist, the column contributes (pp[2k][c-2k] | pp[2k+1][c-2k-1]) * 2^c instead of their sum.
- All other bits, and all bits when exact = 1, are summed exactly.
- p is the modulo-free 2*WIDTH-bit sum; no overflow is possible because approximation never exceeds the exact product.
- Stage 1: register x, y, exact; form the pair sums (HA or OR) per pair into WIDTH/2 rows of WIDTH+2 bits.
- Stage 2: add the rows into two partial sums (pairs 0..WIDTH/4-1 and the rest).
- Stage 3: final add into p.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational. When adv = 0, all stage registers, valids and data hold.
- Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
- Latency: 3 cycles when unstalled. Operands accepted at edge n → out_valid = 1 after edge n+3.
- Throughput: 1 per cycle.
- Bubbles advance with adv; they are not squeezed while stalled.
- Stage valid bits shift on adv. A stage whose input is invalid loads valid = 0; its data is don't-care, but p holds its last value when out_valid = 0.
- txn_count increments on each input transfer and saturates at 2^CNT_W-1, with no wrap.
- Reset, checked at the clock edge with rst_n = 0: all stage valids = 0, out_valid = 0, p = 0, p_exact_flag = 0, txn_count = 0. in_ready = 1 one cycle after reset deasserts.
- Reset mid-operation discards all in-flight transactions; no partial output is produced.
- Simultaneous output transfer and input transfer in the same cycle is legal; both occur.
- in_valid dropping while in_ready = 0 is permitted; no transfer occurs.
- APPROX_COLS = 0 or exact = 1 → p = x*y bit-exact.
- APPROX_COLS >= 2*WIDTH approximates all overlapping pair columns.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0, p = 0, txn_count = 0 throughout; in_ready = 1 after release.
- WIDTH = 8, APPROX_COLS = 4, exact = 0:
  - x = 255, y = 255 → p = 65003 three cycles later (exact 65025; loss 2+4+8 from pair 0, 8 from pair 1).
  - x = 3, y = 3 → p = 7.
  - x = 1, y = 1 → p = 1.
  - x = 0, y = 200 → p = 0.
- Exact mode: x = 3, y = 3, exact = 1 → p = 9, p_exact_flag = 1. Randomised 10k operands with exact = 1 → p == x*y.
- Backpressure: stream 5 back-to-back transactions, hold out_ready = 0 for 4 cycles after the first out_valid → in_ready = 0 during the stall, no data loss, order preserved, txn_count = 5.
- Saturation: CNT_W = 4, 20 transfers → txn_count = 15, held.
- Reset mid-stream: assert rst_n = 0 with 3 in-flight transactions → no stale out_valid after release, txn_count = 0.

Source files
------------

// File: rtl/approx_mul_if.sv
// Operand/product handshake bundle for approx_mul_pipe.
// master = operand producer + product consumer, slave = the multiplier pipeline.
`timescale 1ns/1ps
interface approx_mul_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 exact;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 p_exact_flag;
   logic [CNT_W-1:0]     txn_count;

   modport master (
      output in_valid, x, y, exact, out_ready,
      input  in_ready, out_valid, p, p_exact_flag, txn_count
   );

   modport slave (
      input  in_valid, x, y, exact, out_ready,
      output in_ready, out_valid, p, p_exact_flag, txn_count
   );
endinterface

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned WIDTH x WIDTH multiplier whose low product columns may
// OR-combine adjacent partial-product rows instead of adding them exactly.
`timescale 1ns/1ps
module approx_mul_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 4,
   parameter int CNT_W       = 16
) (
   input logic        clk,
   input logic        rst_n,
   approx_mul_if.slave bus
);
   localparam int PAIRS    = WIDTH / 2;
   localparam int LO_PAIRS = WIDTH / 4;
   localparam int RW       = WIDTH + 2;
   localparam int PW       = 2 * WIDTH;

   // Relative bit positions of pair k where both rows overlap and the absolute column is approximated.
   function automatic logic [RW-1:0] approx_mask(input int k);
      logic [RW-1:0] m;
      m = '0;
      for (int r = 1; r < WIDTH; r++) begin
         if ((2 * k + r) < APPROX_COLS) begin
            m[r] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic [RW-1:0] pair_sum(input logic [WIDTH-1:0] xv, input logic [1:0] yb,
                                              input logic approx, input logic [RW-1:0] m);
      logic [RW-1:0] a;
      logic [RW-1:0] b;
      logic [RW-1:0] mm;
      a  = {2'b00, xv & {WIDTH{yb[0]}}};
      b  = {1'b0, xv & {WIDTH{yb[1]}}, 1'b0};
      mm = approx ? m : {RW{1'b0}};
      return ((a & ~mm) + (b & ~mm)) + ((a | b) & mm);
   endfunction

   logic                adv_s;
   logic                in_xfer_s;
   logic                v0_r, v1_r, v2_r, out_valid_r;
   logic [WIDTH-1:0]    x_r, y_r;
   logic                exact0_r, exact1_r, exact2_r, flag_r;
   logic [RW-1:0]       rows_s [PAIRS];
   logic [RW-1:0]       row_r  [PAIRS];
   logic [PW-1:0]       lo_s, hi_s, sum_lo_r, sum_hi_r, p_r;
   logic [CNT_W-1:0]    cnt_r;

   assign adv_s     = !out_valid_r || bus.out_ready;
   assign in_xfer_s = bus.in_valid && adv_s;

   // Pair-row formation from the registered operands.
   always_comb begin
      for (int k = 0; k < PAIRS; k++) begin
         rows_s[k] = pair_sum(x_r, y_r[2*k +: 2], !exact0_r, approx_mask(k));
      end
   end

   // Split the weighted rows into a low-pair and a high-pair partial sum.
   always_comb begin
      lo_s = '0;
      hi_s = '0;
      for (int k = 0; k < PAIRS; k++) begin
         if (k < LO_PAIRS) begin
            lo_s = lo_s + (PW'(row_r[k]) << (2 * k));
         end else begin
            hi_s = hi_s + (PW'(row_r[k]) << (2 * k));
         end
      end
   end

   // Pipeline registers; everything holds while the output is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_r        <= 1'b0;
         v1_r        <= 1'b0;
         v2_r        <= 1'b0;
         out_valid_r <= 1'b0;
         x_r         <= '0;
         y_r         <= '0;
         exact0_r    <= 1'b0;
         exact1_r    <= 1'b0;
         exact2_r    <= 1'b0;
         flag_r      <= 1'b0;
         for (int k = 0; k < PAIRS; k++) begin
            row_r[k] <= '0;
         end
         sum_lo_r    <= '0;
         sum_hi_r    <= '0;
         p_r         <= '0;
      end else if (adv_s) begin
         v0_r        <= bus.in_valid;
         v1_r        <= v0_r;
         v2_r        <= v1_r;
         out_valid_r <= v2_r;
         if (bus.in_valid) begin
            x_r      <= bus.x;
            y_r      <= bus.y;
            exact0_r <= bus.exact;
         end
         if (v0_r) begin
            for (int k = 0; k < PAIRS; k++) begin
               row_r[k] <= rows_s[k];
            end
            exact1_r <= exact0_r;
         end
         if (v1_r) begin
            sum_lo_r <= lo_s;
            sum_hi_r <= hi_s;
            exact2_r <= exact1_r;
         end
         // p keeps its last product across bubbles.
         if (v2_r) begin
            p_r    <= sum_lo_r + sum_hi_r;
            flag_r <= exact2_r;
         end
      end
   end

   // Saturating count of accepted transactions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (in_xfer_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.in_ready     = adv_s;
   assign bus.out_valid    = out_valid_r;
   assign bus.p            = p_r;
   assign bus.p_exact_flag = flag_r;
   assign bus.txn_count    = cnt_r;
endmodule
